// File: rtl/store_buffer.sv
// store_buffer: write-posting FIFO between MEM stage and data memory, retiring stores on free port cycles
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   MEMread_in           load request from the MEM stage
//   MEMwrite_in          store request from the MEM stage
//   address_in, data_in  request byte address (bits [31:2] used) and store data
//   flush                drain every queued store before continuing
//   MEM_Result_out       load data returned to the pipeline
//   freeze               stall; the current request is not consumed
//   MEMread, MEMwrite    data memory read / write enables
//   address, data        data memory address and write data
//   MEM_Result           data memory read data (combinational from address)
//   count                number of occupied entries
//
// Optional feature: define STORE_FWD_EN to serve loads that hit queued stores
// from the buffer; otherwise such loads freeze until the hits have drained.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MEMread_in,
    input  logic                       MEMwrite_in,
    input  logic [31:0]                address_in,
    input  logic [31:0]                data_in,
    input  logic                       flush,
    output logic [31:0]                MEM_Result_out,
    output logic                       freeze,
    output logic                       MEMread,
    output logic                       MEMwrite,
    output logic [31:0]                address,
    output logic [31:0]                data,
    input  logic [31:0]                MEM_Result,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [29:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   cnt;
    logic          hit, flushing, load_cycle, drain, push;
    logic          unused_low_bits;
`ifdef STORE_FWD_EN
    logic [31:0]   fwd_data;
`endif

    assign unused_low_bits = ^address_in[1:0];

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < cnt && q_addr[head + AW'(k)] == address_in[31:2]) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                fwd_data = q_data[head + AW'(k)];
`endif
            end
        end
    end

    assign flushing = flush && cnt != '0;
`ifdef STORE_FWD_EN
    assign freeze = flushing;
    assign MEM_Result_out = !MEMread_in ? '0 : hit ? fwd_data : MEM_Result;
`else
    assign freeze = flushing || (MEMread_in && hit);
    assign MEM_Result_out = MEMread_in ? MEM_Result : '0;
`endif

    // A frozen load gives the port to the drain so the blocking entry can retire.
    assign load_cycle = MEMread_in && !freeze;
    assign drain      = cnt != '0 && !load_cycle;
    assign push       = MEMwrite_in && !MEMread_in && !freeze;

    assign MEMread  = load_cycle;
    assign MEMwrite = drain;
    assign address  = load_cycle ? address_in : drain ? {q_addr[head], 2'b00} : '0;
    assign data     = drain ? q_data[head] : '0;
    assign count    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(drain);
            tail <= tail + AW'(push);
            cnt  <= cnt + (AW+1)'(push) - (AW+1)'(drain);
        end
    end

    // A push into a full buffer always coincides with a pop, so tail never overruns head.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= address_in[31:2];
            q_data[tail] <= data_in;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table vectors, corner sequences and random traffic checked against a queue model
module tb_store_buffer;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        MEMread_in = 1'b0, MEMwrite_in = 1'b0, flush = 1'b0;
    logic [31:0] address_in = '0, data_in = '0;
    logic [31:0] MEM_Result_out, address, data, MEM_Result;
    logic        freeze, MEMread, MEMwrite;
    logic [2:0]  count;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .MEMread_in(MEMread_in), .MEMwrite_in(MEMwrite_in),
        .address_in(address_in), .data_in(data_in), .flush(flush),
        .MEM_Result_out(MEM_Result_out), .freeze(freeze), .MEMread(MEMread),
        .MEMwrite(MEMwrite), .address(address), .data(data),
        .MEM_Result(MEM_Result), .count(count)
    );

    always #5 clk = ~clk;

    logic [31:0] env_mem [1024];
    assign MEM_Result = env_mem[address[11:2]];
    always @(posedge clk) if (MEMwrite) env_mem[address[11:2]] <= data;

    typedef struct { logic [29:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [1024];
    logic        m_dr, m_acc;
    int          n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Apply one request, then at mid-cycle compare every output with the queue model.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic fl);
        logic        hit, fr, ld;
        logic [31:0] fd, exp_res;
        MEMread_in = rd; MEMwrite_in = wr; address_in = a; data_in = d; flush = fl;
        #4;
        hit = 1'b0; fd = '0;
        foreach (q[i]) if (q[i].a == a[31:2]) begin hit = 1'b1; fd = q[i].d; end
        fr    = (fl && q.size() != 0) || (!FWD && rd && hit);
        ld    = rd && !fr;
        m_dr  = q.size() != 0 && !ld;
        m_acc = wr && !rd && !fr;
        exp_res = !rd ? 32'h0 : (FWD && hit) ? fd : ref_mem[a[11:2]];
        chk("m_freeze", {31'b0, freeze}, {31'b0, fr});
        chk("m_MEMread", {31'b0, MEMread}, {31'b0, ld});
        chk("m_MEMwrite", {31'b0, MEMwrite}, {31'b0, m_dr});
        chk("m_address", address, ld ? a : m_dr ? {q[0].a, 2'b00} : 32'h0);
        chk("m_data", data, m_dr ? q[0].d : 32'h0);
        chk("m_count", {29'b0, count}, 32'(q.size()));
        if (!fr) chk("m_result", MEM_Result_out, exp_res);
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_dr) begin ref_mem[q[0].a[9:0]] = q[0].d; void'(q.pop_front()); end
        if (m_acc) q.push_back('{address_in[31:2], data_in});
        #1;
    endtask

    typedef struct {
        logic rd, wr, fl; logic [31:0] a, d;
        logic e_fr, e_mw, e_mr; logic [2:0] e_cnt; logic [31:0] e_res;
    } vec_t;
    vec_t vec [17];

    initial begin
        int base [5] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h100};
        for (int i = 0; i < 1024; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
        //            rd wr fl addr          data          fr mw mr cnt res
        vec[0]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0};
        vec[1]  = '{0, 1, 0, 32'h400, 32'h11223344, 0, 0, 0, 0, 32'h0};
        vec[2]  = '{0, 0, 0, 32'h0,   32'h0,        0, 1, 0, 1, 32'h0};
        vec[3]  = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0};
        vec[4]  = '{1, 0, 0, 32'h400, 32'h0,        0, 0, 1, 0, 32'h11223344};
        vec[5]  = '{0, 1, 0, 32'h404, 32'hA,        0, 0, 0, 0, 32'h0};
        vec[6]  = '{1, 0, 0, 32'h100, 32'h0,        0, 0, 1, 1, 32'h0};
        vec[7]  = '{0, 1, 0, 32'h404, 32'hB,        0, 1, 0, 1, 32'h0};
`ifdef STORE_FWD_EN
        vec[8]  = '{1, 0, 0, 32'h406, 32'h0,        0, 0, 1, 1, 32'hB};
        vec[9]  = '{1, 0, 0, 32'h406, 32'h0,        0, 0, 1, 1, 32'hB};
        vec[10] = '{0, 0, 0, 32'h0,   32'h0,        0, 1, 0, 1, 32'h0};
`else
        vec[8]  = '{1, 0, 0, 32'h406, 32'h0,        1, 1, 0, 1, 32'h0};
        vec[9]  = '{1, 0, 0, 32'h406, 32'h0,        0, 0, 1, 0, 32'hB};
        vec[10] = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0};
`endif
        vec[11] = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0};
        vec[12] = '{0, 1, 0, 32'h408, 32'h55,       0, 0, 0, 0, 32'h0};
        vec[13] = '{1, 0, 1, 32'h100, 32'h0,        1, 1, 0, 1, 32'h0};
        vec[14] = '{0, 0, 1, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0};
        vec[15] = '{1, 1, 0, 32'h408, 32'h99,       0, 0, 1, 0, 32'h55};
        vec[16] = '{1, 0, 0, 32'h408, 32'h0,        0, 0, 1, 0, 32'h55};

        #12;
        chk("rst_count", {29'b0, count}, 32'h0);
        chk("rst_MEMwrite", {31'b0, MEMwrite}, 32'h0);
        chk("rst_result", MEM_Result_out, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        foreach (vec[i]) begin
            drive(vec[i].rd, vec[i].wr, vec[i].a, vec[i].d, vec[i].fl);
            chk($sformatf("v%0d_freeze", i), {31'b0, freeze}, {31'b0, vec[i].e_fr});
            chk($sformatf("v%0d_MEMwrite", i), {31'b0, MEMwrite}, {31'b0, vec[i].e_mw});
            chk($sformatf("v%0d_MEMread", i), {31'b0, MEMread}, {31'b0, vec[i].e_mr});
            chk($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, vec[i].e_cnt});
            if (!vec[i].e_fr) chk($sformatf("v%0d_result", i), MEM_Result_out, vec[i].e_res);
            advance();
        end

        // Store then reset while it is draining: it must vanish and never reach memory.
        drive(0, 1, 32'h40C, 32'hDEAD, 0); advance();
        drive(0, 0, 32'h0, 32'h0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_count", {29'b0, count}, 32'h0);
        chk("rst_mid_MEMwrite", {31'b0, MEMwrite}, 32'h0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin drive(0, 0, 32'h0, 32'h0, 0); advance(); end
        drive(1, 0, 32'h40C, 32'h0, 0);
        chk("rst_lost_store", MEM_Result_out, 32'h0);
        advance();

        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a = 32'(base[$urandom_range(0, 4)]) | 32'($urandom_range(0, 3));
            drive(r < 4 || r == 9, r >= 4, a, $urandom, $urandom_range(0, 9) == 0);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
